cpu_bus_responder: RTL

Memory-side responder for the CPU16 bus: owns the main 16-bit word RAM and a small memory-mapped I/O window. It answers CPU16 reads and writes with fixed latency. It arbitrates the bus for the video scanout reader by asserting `hold` toward the CPU and granting burst reads once the CPU reports `busy`. It sits between CPU16, the video line fetcher and the board I/O (keys, LEDs).

---
 rtl/cpu_bus_pkg.sv | 17 +
 rtl/bus_ram.sv | 26 ++
 rtl/cpu_bus_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU16 bus responder:
// arbiter state encoding, I/O window offsets and the default window base.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ARB_CPU,
        ARB_REQ,
        ARB_VID,
        ARB_REL
    } arb_state_t;

    localparam logic [3:0]  IO_KEYS         = 4'd0;
    localparam logic [3:0]  IO_LEDS         = 4'd1;
    localparam logic [3:0]  IO_CNT          = 4'd2;
    localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;

endpackage

// File: rtl/bus_ram.sv
// Single-port synchronous word RAM: one access per cycle, registered read data.
// Reads return the contents from before a same-cycle write.
module bus_ram #(
    parameter int ADDR_BITS = 12,
    parameter int DATA_W    = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_BITS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU16 memory-side responder: word RAM, small I/O window, and a hold/grant
// arbiter that hands the RAM to the video line fetcher for fixed-length bursts.
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int          ADDR_BITS = 12,
    parameter int          BURST     = 16,
    parameter logic [15:0] IO_BASE   = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_write,
    input  logic        cpu_busy,
    output logic [15:0] cpu_rdata,
    output logic        hold,
    input  logic        vid_req,
    input  logic [15:0] vid_base,
    output logic        vid_valid,
    output logic [15:0] vid_data,
    output logic        vid_done,
    input  logic [7:0]  keys,
    output logic [7:0]  leds
);

    localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

    arb_state_t           state_q, state_d;
    logic [ADDR_BITS-1:0] base_q, base_d;
    logic [7:0]           word_q, word_d;
    logic [7:0]           leds_q, leds_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [7:0]           key_s1_q, key_s1_d;
    logic [7:0]           key_s2_q, key_s2_d;
    logic                 ram_sel_q, ram_sel_d;
    logic [15:0]          io_rdata_q, io_rdata_d;
    logic                 vid_valid_q, vid_valid_d;
    logic                 vid_done_q, vid_done_d;

    logic                 in_vid;
    logic                 io_hit;
    logic                 ram_hit;
    logic                 cpu_wr;
    logic [3:0]           io_off;
    logic [ADDR_BITS-1:0] ram_addr;
    logic                 ram_we;
    logic [15:0]          ram_rdata;

    always_comb begin
        in_vid  = (state_q == ARB_VID);
        io_hit  = (cpu_address[15:4] == IO_BASE[15:4]);
        ram_hit = !io_hit && ({16'h0000, cpu_address} < (32'd1 << ADDR_BITS));
        io_off  = cpu_address[3:0];
        // The CPU is locked out of the RAM port for the whole burst.
        cpu_wr  = cpu_write && !in_vid;
        ram_we  = cpu_wr && ram_hit;
        ram_addr = in_vid ? (base_q + ADDR_BITS'(word_q)) : cpu_address[ADDR_BITS-1:0];
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        word_d  = word_q;
        hold    = 1'b0;
        case (state_q)
            ARB_CPU: begin
                if (vid_req) state_d = ARB_REQ;
            end
            ARB_REQ: begin
                hold = 1'b1;
                if (cpu_busy && !cpu_write) begin
                    state_d = ARB_VID;
                    base_d  = vid_base[ADDR_BITS-1:0];
                    word_d  = '0;
                end
            end
            ARB_VID: begin
                hold   = 1'b1;
                word_d = word_q + 8'd1;
                if (word_q == BURST_LAST) state_d = ARB_REL;
            end
            ARB_REL: begin
                state_d = ARB_CPU;
            end
            default: state_d = ARB_CPU;
        endcase
    end

    always_comb begin
        leds_d     = leds_q;
        cnt_d      = cnt_q + 16'd1;
        key_s1_d   = keys;
        key_s2_d   = key_s1_q;
        io_rdata_d = '0;
        if (cpu_wr && io_hit) begin
            case (io_off)
                IO_LEDS: leds_d = cpu_wdata[7:0];
                IO_CNT:  cnt_d  = '0;
                default: ;
            endcase
        end
        if (!in_vid && io_hit) begin
            case (io_off)
                IO_KEYS: io_rdata_d = {8'h00, key_s2_q};
                IO_LEDS: io_rdata_d = {8'h00, leds_q};
                IO_CNT:  io_rdata_d = cnt_q;
                default: io_rdata_d = '0;
            endcase
        end
        ram_sel_d   = !in_vid && ram_hit;
        vid_valid_d = in_vid;
        vid_done_d  = (state_q == ARB_REL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_CPU;
            base_q      <= '0;
            word_q      <= '0;
            leds_q      <= '0;
            cnt_q       <= '0;
            key_s1_q    <= '0;
            key_s2_q    <= '0;
            ram_sel_q   <= 1'b0;
            io_rdata_q  <= '0;
            vid_valid_q <= 1'b0;
            vid_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            word_q      <= word_d;
            leds_q      <= leds_d;
            cnt_q       <= cnt_d;
            key_s1_q    <= key_s1_d;
            key_s2_q    <= key_s2_d;
            ram_sel_q   <= ram_sel_d;
            io_rdata_q  <= io_rdata_d;
            vid_valid_q <= vid_valid_d;
            vid_done_q  <= vid_done_d;
        end
    end

    bus_ram #(
        .ADDR_BITS(ADDR_BITS),
        .DATA_W   (16)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(cpu_wdata),
        .rdata(ram_rdata)
    );

    // RAM data is shared; the registered selects decide who sees it.
    assign cpu_rdata = ram_sel_q ? ram_rdata : io_rdata_q;
    assign vid_data  = vid_valid_q ? ram_rdata : 16'h0000;
    assign vid_valid = vid_valid_q;
    assign vid_done  = vid_done_q;
    assign leds      = leds_q;

    logic unused_ok;
    assign unused_ok = ^{cpu_wdata[15:8], vid_base[15:0]};

endmodule
